sa_autosa_sdp_wdma_split: RTL and testbench
===========================================

Name: sa_autosa_sdp_wdma_split

Overview:
- Write-side counterpart of the SDP RDMA gather path.
- Accepts one wide packed word per handshake: ATOMS atoms of ATOM_W bits each, plus a per-atom valid mask.
- Serialises the word into narrow beats of OUT_ATOMS atoms each, for the memory-write interface.
- Forwards the mask slice with every beat, flags the last beat of each word, and propagates an end-of-surface marker.

Parameters:
- ATOM_W, 256: width of one atom in bits.
- ATOMS, 4: atoms per input word.
- OUT_ATOMS, 1: atoms per output beat. Legal values are 1, 2 and 4; ATOMS must be a multiple of OUT_ATOMS.
- RATIO, ATOMS/OUT_ATOMS (derived, not overridden): maximum beats per word.

Ports:
- autosa_core_clk  in  1  core clock; all state updates on its rising edge.
- autosa_core_rst  in  1  asynchronous, active-high reset.
- inp_pvld  in  1  input word valid.
- inp_prdy  out  1  input word ready.
- inp_data  in  ATOMS*ATOM_W+ATOMS  {mask[ATOMS-1:0], data[ATOMS*ATOM_W-1:0]}; atom k is data[k*ATOM_W +: ATOM_W].
- inp_end  in  1  word is the last of the surface; sampled with inp_data.
- out_pvld  out  1  output beat valid.
- out_prdy  in  1  output beat ready.
- out_data  out  OUT_ATOMS*ATOM_W+OUT_ATOMS  {beat_mask[OUT_ATOMS-1:0], beat_data}.
- out_last  out  1  current beat is the final beat of its word.
- out_end  out  1  out_last & stored end flag of the current word.

Behaviour:
- Reset values: inp_prdy=1, out_pvld=0, out_last=0, out_end=0, out_data=0, beat counter=0, busy=0.
- Handshakes: inp_acc = inp_pvld & inp_prdy; out_acc = out_pvld & out_prdy.
- inp_prdy = !busy | (out_acc & out_last). It is combinational from out_prdy, so a new word loads in the same cycle the old word's last beat leaves: no bubble.
- On inp_acc, register word, mask and end flag; set busy; clear the beat counter.
  - Beat count nb = floor(msb/OUT_ATOMS)+1, where msb is the index of the highest set mask bit.
- Latency: word accepted in cycle N gives its first beat with out_pvld=1 in cycle N+1, driven only from registers.
- Beat i (i = 0..nb-1):
  - beat_data = stored data atoms [i*OUT_ATOMS +: OUT_ATOMS].
  - beat_mask = stored mask bits [i*OUT_ATOMS +: OUT_ATOMS], copied unchanged; holes in the mask are forwarded, not compacted.
- out_last = busy & (cnt == nb-1).
- On out_acc & !out_last: cnt increments.
- On out_acc & out_last: busy clears, unless inp_acc occurs in the same cycle, which reloads the word.
- mask==0:
  - The word is accepted and discarded; no beats are emitted and busy stays 0.
  - If inp_end=1 on that word, the end is latched as pending and asserted with out_last on the next emitted word's last beat.
- Backpressure: while out_pvld=1 & out_prdy=0, out_data, out_last and out_end hold stable and inp_prdy=0.
- Throughput: sustained rate is one beat per cycle; a full-mask word with OUT_ATOMS=1 occupies 4 cycles.
- Counter width is clog2(RATIO) bits, minimum 1. The counter never wraps past nb-1.
- Reset asserted mid-word:
  - The partially sent word and any pending end are dropped.
  - All outputs return to reset values asynchronously.
  - After deassertion the first accepted word starts at beat 0.
- State machine: IDLE (busy=0) and SEND (busy=1).
  - IDLE→SEND on inp_acc with mask≠0.
  - SEND→IDLE on out_acc & out_last with no same-cycle inp_acc.
  - SEND→SEND on last beat with reload.
- Parameter check: a simulation-time error fires if ATOMS%OUT_ATOMS≠0 or OUT_ATOMS is not in {1,2,4}.

Test Plan:
1. Full word, OUT_ATOMS=1: mask=4'hf, atoms A0..A3, out_prdy=1 → beats A0,A1,A2,A3 in cycles N+1..N+4; beat_mask=1 each; out_last only on A3.
2. Partial word: mask=4'h3 with inp_end=1 → 2 beats A0,A1; out_last=out_end=1 on A1; inp_prdy=1 in the A1 cycle.
3. Back-to-back: three words with mask=4'hf, inp_pvld held high → 12 consecutive beats, no gap cycles, inp_prdy pulses exactly on beats 4, 8, 12.
4. Backpressure: out_prdy toggled 1,0,0,1,... pseudo-randomly → beat order and content unchanged, out_data stable while stalled, no duplicated or lost beats against a scoreboard.
5. OUT_ATOMS=2, mask=4'h5 → 2 beats: {mask 2'b01, A1:A0}, then {mask 2'b01, A3:A2}. Mask=4'h1 → 1 beat with out_last.
6. Edge cases:
   - mask=0 with inp_end=1, then mask=4'h1 → a single beat with out_last=out_end=1.
   - Reset asserted after beat 1 of a 4-beat word → out_pvld=0 immediately; next word starts at A0.

Source files
------------

// File: rtl/sa_autosa_sdp_wdma_split.sv
// sa_autosa_sdp_wdma_split
// Splits one wide masked word (ATOMS atoms) into narrow memory-write beats of
// OUT_ATOMS atoms each. The mask slice travels with every beat, the final beat
// of a word is flagged, and an end-of-surface marker rides on that final beat.
// Words whose mask is all zero are swallowed, and their end marker is carried
// forward to the next word that does emit beats.
module sa_autosa_sdp_wdma_split #(
  parameter int ATOM_W    = 256,
  parameter int ATOMS     = 4,
  parameter int OUT_ATOMS = 1
) (
  input  logic                                 autosa_core_clk,
  input  logic                                 autosa_core_rst,
  input  logic                                 inp_pvld,
  output logic                                 inp_prdy,
  input  logic [ATOMS*ATOM_W+ATOMS-1:0]         inp_data,
  input  logic                                 inp_end,
  output logic                                 out_pvld,
  input  logic                                 out_prdy,
  output logic [OUT_ATOMS*ATOM_W+OUT_ATOMS-1:0] out_data,
  output logic                                 out_last,
  output logic                                 out_end
);

  localparam int RATIO  = ATOMS / OUT_ATOMS;
  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DATA_W = ATOMS * ATOM_W;
  localparam int BEAT_W = OUT_ATOMS * ATOM_W;

  // Reject geometries the beat slicing cannot represent.
  if (((ATOMS % OUT_ATOMS) != 0) ||
      !((OUT_ATOMS == 1) || (OUT_ATOMS == 2) || (OUT_ATOMS == 4))) begin : g_param_err
    $error("sa_autosa_sdp_wdma_split: OUT_ATOMS must be 1, 2 or 4 and divide ATOMS");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_q;
  logic [ATOMS-1:0]    mask_q;
  logic                end_q;     // end marker of the word being sent
  logic                end_pend;  // end marker inherited from a discarded empty word
  logic [CNT_W-1:0]    cnt;       // index of the beat currently presented
  logic [CNT_W-1:0]    last_q;    // index of the final beat of the current word

  logic                busy;
  logic                inp_acc;
  logic                out_acc;
  logic [DATA_W-1:0]   inp_word;
  logic [ATOMS-1:0]    inp_mask;
  logic [BEAT_W-1:0]   beat_data;
  logic [OUT_ATOMS-1:0] beat_mask;

  // Index of the last beat holding the highest set mask bit.
  function automatic logic [CNT_W-1:0] last_beat(input logic [ATOMS-1:0] mask);
    logic [CNT_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < ATOMS; k++) begin
      if (mask[k]) idx = CNT_W'(k / OUT_ATOMS);
    end
    return idx;
  endfunction

  assign inp_word = inp_data[DATA_W-1:0];
  assign inp_mask = inp_data[DATA_W +: ATOMS];

  assign busy     = (state == SEND);
  assign out_pvld = busy;
  assign out_last = busy && (cnt == last_q);
  assign out_end  = out_last && end_q;
  assign out_acc  = out_pvld && out_prdy;
  // Ready while idle, or when the last beat of the current word leaves this
  // cycle, so a following word loads with no bubble in between.
  assign inp_prdy = !busy || (out_acc && out_last);
  assign inp_acc  = inp_pvld && inp_prdy;

  // Select the stored atoms and mask bits of the beat addressed by cnt.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    beat_data = '0;
    beat_mask = '0;
    for (int b = 0; b < RATIO; b++) begin
      if (cnt == CNT_W'(b)) begin
        beat_data = data_q[b*BEAT_W +: BEAT_W];
        beat_mask = mask_q[b*OUT_ATOMS +: OUT_ATOMS];
      end
    end
  end

  assign out_data = {beat_mask, beat_data};

  // Word capture, beat sequencing and the IDLE/SEND state machine.
  always_ff @(posedge autosa_core_clk or posedge autosa_core_rst) begin
    if (autosa_core_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_q   <= '0;
      // NOTE: the word store is reset too, because out_data is defined to read zero in reset.
      data_q   <= '0;
      mask_q   <= '0;
      end_q    <= 1'b0;
      end_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (inp_acc) begin
        if (inp_mask != '0) begin
          state    <= SEND;
          cnt      <= '0;
          last_q   <= last_beat(inp_mask);
          data_q   <= inp_word;
          mask_q   <= inp_mask;
          end_q    <= inp_end || end_pend;
          end_pend <= 1'b0;
        end else begin
          // Empty word: nothing to emit. If a word was finishing this cycle
          // it has left, so the block goes idle either way.
          state <= IDLE;
          if (inp_end) end_pend <= 1'b1;
        end
      end else if (out_acc) begin
        if (out_last) state <= IDLE;
        else          cnt   <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sa_autosa_sdp_wdma_split.sv
// Directed bench for sa_autosa_sdp_wdma_split: a word-level vector table on a
// one-atom-per-beat instance, plus hand-written sequences for back-to-back
// loading, backpressure, a two-atom-per-beat instance and mid-word reset.
module tb_sa_autosa_sdp_wdma_split;

  localparam int AW = 16;

  logic        clk;
  logic        rst;

  logic        inp_pvld, inp_prdy, inp_end;
  logic [67:0] inp_data;
  logic        out_pvld, out_prdy, out_last, out_end;
  logic [16:0] out_data;

  logic        inp2_pvld, inp2_prdy, inp2_end;
  logic [67:0] inp2_data;
  logic        out2_pvld, out2_prdy, out2_last, out2_end;
  logic [33:0] out2_data;

  int n_checks = 0;
  int n_err    = 0;

  sa_autosa_sdp_wdma_split #(.ATOM_W(AW), .ATOMS(4), .OUT_ATOMS(1)) u_dut1 (
    .autosa_core_clk (clk),
    .autosa_core_rst (rst),
    .inp_pvld        (inp_pvld),
    .inp_prdy        (inp_prdy),
    .inp_data        (inp_data),
    .inp_end         (inp_end),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .out_data        (out_data),
    .out_last        (out_last),
    .out_end         (out_end)
  );

  sa_autosa_sdp_wdma_split #(.ATOM_W(AW), .ATOMS(4), .OUT_ATOMS(2)) u_dut2 (
    .autosa_core_clk (clk),
    .autosa_core_rst (rst),
    .inp_pvld        (inp2_pvld),
    .inp_prdy        (inp2_prdy),
    .inp_data        (inp2_data),
    .inp_end         (inp2_end),
    .out_pvld        (out2_pvld),
    .out_prdy        (out2_prdy),
    .out_data        (out2_data),
    .out_last        (out2_last),
    .out_end         (out2_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  mask;
    logic        eos;
    logic [63:0] data;
    int          nb;
    logic        exp_end;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Four consecutive atoms starting at base, atom 0 in the low bits.
  function automatic logic [63:0] mk(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  // Beats a one-atom-per-beat instance emits for a mask: highest set bit + 1.
  function automatic int beats_of(input logic [3:0] mask);
    int n;
    n = 0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k] && n == 0) n = k + 1;
    end
    return n;
  endfunction

  // Apply one word to u_dut1 with out_prdy high and check every beat.
  // Entered and left just after a rising edge.
  task automatic run_row(input vec_t v, input string tag);
    inp_data = {v.mask, v.data};
    inp_end  = v.eos;
    inp_pvld = 1'b1;
    @(negedge clk);
    check({tag, " accept prdy"}, inp_prdy, 1'b1);
    @(posedge clk); #1;
    inp_pvld = 1'b0;
    inp_end  = 1'b0;
    for (int b = 0; b < v.nb; b++) begin
      @(negedge clk);
      check($sformatf("%s beat%0d", tag, b),
            {out_pvld, out_last, out_end, out_data},
            {1'b1, (b == v.nb - 1), (b == v.nb - 1) & v.exp_end, v.mask[b], v.data[b*AW +: AW]});
      check($sformatf("%s prdy%0d", tag, b), inp_prdy, (b == v.nb - 1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check({tag, " idle after"}, out_pvld, 1'b0);
    @(posedge clk); #1;
  endtask

  // Three full words with inp_pvld held high: twelve beats without gaps.
  task automatic run_b2b();
    logic [63:0] bw [3];
    int idx;
    for (int w = 0; w < 3; w++) bw[w] = mk(16'h3000 + 16'(w * 256));
    inp_end  = 1'b0;
    inp_data = {4'hf, bw[0]};
    inp_pvld = 1'b1;
    @(negedge clk);
    check("b2b first prdy", inp_prdy, 1'b1);
    @(posedge clk); #1;
    idx = 1;
    inp_data = {4'hf, bw[1]};
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      check($sformatf("b2b beat%0d", j),
            {out_pvld, out_last, out_end, out_data},
            {1'b1, ((j % 4) == 3), 1'b0, 1'b1, bw[j/4][(j%4)*AW +: AW]});
      check($sformatf("b2b prdy%0d", j), inp_prdy, ((j % 4) == 3));
      @(posedge clk); #1;
      if ((j % 4) == 3) begin
        idx++;
        if (idx < 3) inp_data = {4'hf, bw[idx]};
        else         inp_pvld = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b idle after", out_pvld, 1'b0);
    @(posedge clk); #1;
  endtask

  // Random out_prdy against a scoreboard of expected beats.
  task automatic run_backpressure();
    logic [18:0] exp_q [$];
    logic [63:0] bw [3];
    logic [3:0]  bm [3];
    logic        be [3];
    logic [18:0] obs, held, exp_v;
    logic        stalled, in_acc;
    int idx, got, total, nb;
    bm = '{4'hf, 4'h6, 4'hb};
    be = '{1'b0, 1'b0, 1'b1};
    total = 0;
    for (int w = 0; w < 3; w++) begin
      bw[w] = mk(16'h4000 + 16'(w * 256));
      total += beats_of(bm[w]);
    end
    idx = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && got < total; cyc++) begin
      out_prdy = 1'($urandom_range(0, 1));
      if (idx < 3) begin
        inp_pvld = 1'b1;
        inp_data = {bm[idx], bw[idx]};
        inp_end  = be[idx];
      end else begin
        inp_pvld = 1'b0;
        inp_end  = 1'b0;
      end
      @(negedge clk);
      obs = {out_last, out_end, out_data};
      if (stalled) check("bp held beat", {out_pvld, obs}, {1'b1, held});
      if (out_pvld && !out_prdy) check("bp prdy while stalled", inp_prdy, 1'b0);
      in_acc = inp_pvld & inp_prdy;
      if (out_pvld && out_prdy) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check($sformatf("bp beat%0d", got), obs, exp_v);
        got++;
      end
      stalled = out_pvld & !out_prdy;
      held    = obs;
      if (in_acc) begin
        nb = beats_of(bm[idx]);
        for (int i = 0; i < nb; i++)
          exp_q.push_back({(i == nb - 1), (i == nb - 1) & be[idx], bm[idx][i], bw[idx][i*AW +: AW]});
        idx++;
      end
      @(posedge clk); #1;
    end
    check("bp beats received", got, total);
    out_prdy = 1'b1;
    inp_pvld = 1'b0;
    inp_end  = 1'b0;
    @(negedge clk);
    check("bp idle after", out_pvld, 1'b0);
    @(posedge clk); #1;
  endtask

  // Two atoms per beat on u_dut2.
  task automatic run_two_atom();
    logic [63:0] d;
    d = mk(16'h5000);
    // mask 0101: two beats, each carrying mask slice 01
    inp2_data = {4'h5, d}; inp2_end = 1'b0; inp2_pvld = 1'b1;
    @(negedge clk);
    check("x2 m5 prdy", inp2_prdy, 1'b1);
    @(posedge clk); #1;
    inp2_pvld = 1'b0;
    @(negedge clk);
    check("x2 m5 beat0", {out2_pvld, out2_last, out2_end, out2_data}, {1'b1, 1'b0, 1'b0, 2'b01, d[31:0]});
    @(posedge clk); #1;
    @(negedge clk);
    check("x2 m5 beat1", {out2_pvld, out2_last, out2_end, out2_data}, {1'b1, 1'b1, 1'b0, 2'b01, d[63:32]});
    @(posedge clk); #1;
    @(negedge clk);
    check("x2 m5 idle", out2_pvld, 1'b0);
    @(posedge clk); #1;
    // mask 0100: a hole-only first beat is still sent
    d = mk(16'h5100);
    inp2_data = {4'h4, d}; inp2_pvld = 1'b1;
    @(posedge clk); #1;
    inp2_pvld = 1'b0;
    @(negedge clk);
    check("x2 m4 beat0", {out2_pvld, out2_last, out2_end, out2_data}, {1'b1, 1'b0, 1'b0, 2'b00, d[31:0]});
    @(posedge clk); #1;
    @(negedge clk);
    check("x2 m4 beat1", {out2_pvld, out2_last, out2_end, out2_data}, {1'b1, 1'b1, 1'b0, 2'b01, d[63:32]});
    @(posedge clk); #1;
    // mask 0001 with end: one beat carrying last and end
    d = mk(16'h5200);
    inp2_data = {4'h1, d}; inp2_end = 1'b1; inp2_pvld = 1'b1;
    @(negedge clk);
    check("x2 m1 prdy", inp2_prdy, 1'b1);
    @(posedge clk); #1;
    inp2_pvld = 1'b0; inp2_end = 1'b0;
    @(negedge clk);
    check("x2 m1 beat0", {out2_pvld, out2_last, out2_end, out2_data}, {1'b1, 1'b1, 1'b1, 2'b01, d[31:0]});
    @(posedge clk); #1;
    @(negedge clk);
    check("x2 m1 idle", out2_pvld, 1'b0);
    @(posedge clk); #1;
  endtask

  // Reset in the middle of a word drops it and any end marker it carried.
  task automatic run_mid_reset();
    vec_t v;
    logic [63:0] d;
    v = '{4'h0, 1'b1, mk(16'h6000), 0, 1'b0};
    run_row(v, "rst empty-end");
    d = mk(16'h6100);
    inp_data = {4'hf, d}; inp_end = 1'b0; inp_pvld = 1'b1;
    @(posedge clk); #1;
    inp_pvld = 1'b0;
    @(negedge clk);
    check("rst pre beat0", {out_pvld, out_last, out_end, out_data}, {1'b1, 1'b0, 1'b0, 1'b1, d[15:0]});
    @(posedge clk); #1;
    @(negedge clk);
    check("rst pre beat1", {out_pvld, out_last, out_end, out_data}, {1'b1, 1'b0, 1'b0, 1'b1, d[31:16]});
    #1 rst = 1'b1;
    #1;
    check("rst async outputs", {out_pvld, out_last, out_end, out_data}, 20'h0);
    check("rst async prdy", inp_prdy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    v = '{4'h1, 1'b0, mk(16'h6200), 1, 1'b0};
    run_row(v, "rst next word");
  endtask

  initial begin
    rst       = 1'b1;
    inp_pvld  = 1'b0; inp_end  = 1'b0; inp_data  = '0; out_prdy  = 1'b1;
    inp2_pvld = 1'b0; inp2_end = 1'b0; inp2_data = '0; out2_prdy = 1'b1;

    vecs[0] = '{4'hf, 1'b0, mk(16'h1000), 4, 1'b0};
    vecs[1] = '{4'h3, 1'b1, mk(16'h1100), 2, 1'b1};
    vecs[2] = '{4'h0, 1'b1, mk(16'h1200), 0, 1'b0};
    vecs[3] = '{4'h1, 1'b0, mk(16'h1300), 1, 1'b1};
    vecs[4] = '{4'ha, 1'b0, mk(16'h1400), 4, 1'b0};
    vecs[5] = '{4'h4, 1'b1, mk(16'h1500), 3, 1'b1};

    #3;
    check("reset dut1 outputs", {out_pvld, out_last, out_end, out_data}, 20'h0);
    check("reset dut1 prdy", inp_prdy, 1'b1);
    check("reset dut2 outputs", {out2_pvld, out2_last, out2_end, out2_data}, 37'h0);
    check("reset dut2 prdy", inp2_prdy, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_row(vecs[i], $sformatf("row%0d", i));
    run_b2b();
    run_backpressure();
    run_two_atom();
    run_mid_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
